fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; drives the next-PC selection and the IF/ID pipeline register.
- Consumes the CPU controller's PC-select, PC-write, IF/ID-load and IF/ID-flush outputs; produces the instruction and PC+4 that the ID stage decodes.
- Talks to the instruction memory over a req/ready handshake, so a slow memory inserts bubbles instead of stalling the whole pipe.
- Holds one returned word when ID is stalled; discards in-flight fetches that are killed by a redirect.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_next_pc.sv | 41 ++++
 rtl/fetch_stage.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its sub-module.
// Contents: datapath width, next-PC select encodings, the fetch FSM state
// type, the default no-op instruction word and a PC increment helper.
package cpu_pkg;

  localparam int XLEN = 32;

  // Next-PC select encodings driven by the CPU controller
  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_J   = 2'd2;
  localparam logic [1:0] PC_SRC_JR  = 2'd3;

  // Instruction word loaded into IF/ID on a bubble or flush (sll $0,$0,0)
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // FETCH: a request is outstanding; HOLD: one returned word is buffered
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Sequential successor of a PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC helper for the fetch stage.
// Ports:
//   pc            in   current fetch PC
//   pc_src        in   next-PC select (SEQ/BR/J/JR)
//   pc_write      in   0 while a hazard stall blocks redirects
//   branch_target in   taken-branch address
//   jump_target   in   J/JAL address
//   jr_target     in   JR register value
//   pc4           out  pc + 4 (wrapping)
//   target        out  selected next address
//   redirect      out  non-sequential PC change accepted this cycle
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic            pc_write,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] target,
  output logic            redirect
);

  assign pc4      = pc_plus4(pc);
  assign redirect = (pc_src != PC_SRC_SEQ) & pc_write;

  // Target address multiplexer
  always_comb begin
    target = pc4;
    case (pc_src)
      PC_SRC_SEQ: target = pc4;
      PC_SRC_BR:  target = branch_target;
      PC_SRC_J:   target = jump_target;
      PC_SRC_JR:  target = jr_target;
      default:    target = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: next-PC selection,
// instruction-memory req/ready handshake, one-word hold buffer and the
// IF/ID pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_src, *_target         next-PC select and candidate addresses
//   pc_write                 0 = hazard stall, redirects ignored
//   ifid_load, ifid_flush    IF/ID capture / clear-to-NOP controls
//   imem_req, imem_addr      fetch request (address stable while pending)
//   imem_ready, imem_rdata   request completion and returned word
//   ifid_instr/pc4/valid     IF/ID register contents
// Optional (macro FETCH_PERF_CNT_EN): perf_fetched, perf_bubbles,
// perf_discards counters of consumed words, bubble loads, dropped words.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        pc_write,
  input  logic        ifid_load,
  input  logic        ifid_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_discards
`endif
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;            // address of the next instruction to deliver
  logic [31:0]  req_addr_r, req_addr_s; // address of the outstanding request
  logic         discard_r, discard_s;  // in-flight fetch was killed by a redirect
  logic [31:0]  buf_r, buf_s;
  logic [31:0]  ifid_instr_r, ifid_instr_s;
  logic [31:0]  ifid_pc4_r, ifid_pc4_s;
  logic         ifid_valid_r, ifid_valid_s;

  logic [31:0]  pc4_s, target_s;
  logic         redirect_s, avail_s, consumed_s, dropped_s, bubble_s;
  logic [31:0]  word_s;

  fetch_next_pc u_next_pc (
    .pc            (pc_r),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .pc4           (pc4_s),
    .target        (target_s),
    .redirect      (redirect_s)
  );

  // A word is usable either straight from memory (not killed) or from the buffer
  assign avail_s    = ((state_r == FETCH) & imem_ready & ~discard_r) | (state_r == HOLD);
  assign word_s     = (state_r == HOLD) ? buf_r : imem_rdata;
  // Flush has priority over load, and a redirect kills the word being delivered
  assign consumed_s = ~ifid_flush & ifid_load & avail_s & ~redirect_s;
  assign bubble_s   = ~ifid_flush & ifid_load & ~consumed_s;
  assign dropped_s  = ((state_r == FETCH) & imem_ready & (discard_r | redirect_s)) |
                      ((state_r == HOLD) & redirect_s);

  // Next-state, PC and IF/ID update logic
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_addr_s   = req_addr_r;
    discard_s    = discard_r;
    buf_s        = buf_r;
    ifid_instr_s = ifid_instr_r;
    ifid_pc4_s   = ifid_pc4_r;
    ifid_valid_s = ifid_valid_r;

    if (ifid_flush) begin
      ifid_instr_s = NOP_INSTR;
      ifid_pc4_s   = 32'h0000_0000;
      ifid_valid_s = 1'b0;
    end else if (consumed_s) begin
      ifid_instr_s = word_s;
      ifid_pc4_s   = pc4_s;
      ifid_valid_s = 1'b1;
    end else if (ifid_load) begin
      ifid_instr_s = NOP_INSTR;
      ifid_pc4_s   = 32'h0000_0000;
      ifid_valid_s = 1'b0;
    end else begin
      ifid_valid_s = ifid_valid_r;
    end

    case (state_r)
      FETCH: begin
        if (!imem_ready) begin
          // Request still pending: remember the redirect, keep imem_addr stable
          if (redirect_s) begin
            pc_s      = target_s;
            discard_s = 1'b1;
          end else begin
            discard_s = discard_r;
          end
        end else if (discard_r | redirect_s) begin
          // Stale word: drop it and restart at the (possibly new) PC
          discard_s  = 1'b0;
          pc_s       = redirect_s ? target_s : pc_r;
          req_addr_s = redirect_s ? target_s : pc_r;
        end else if (consumed_s) begin
          pc_s       = pc4_s;
          req_addr_s = pc4_s;
        end else begin
          buf_s   = imem_rdata;
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_s       = target_s;
          req_addr_s = target_s;
          state_s    = FETCH;
        end else if (consumed_s) begin
          pc_s       = pc4_s;
          req_addr_s = pc4_s;
          state_s    = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      discard_r    <= 1'b0;
      buf_r        <= NOP_INSTR;
      ifid_instr_r <= NOP_INSTR;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      discard_r    <= discard_s;
      buf_r        <= buf_s;
      ifid_instr_r <= ifid_instr_s;
      ifid_pc4_r   <= ifid_pc4_s;
      ifid_valid_r <= ifid_valid_s;
    end
  end

  assign imem_req   = (state_r == FETCH);
  assign imem_addr  = req_addr_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc4   = ifid_pc4_r;
  assign ifid_valid = ifid_valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_r, perf_bubbles_r, perf_discards_r;

  // Event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_r  <= 32'd0;
      perf_bubbles_r  <= 32'd0;
      perf_discards_r <= 32'd0;
    end else begin
      perf_fetched_r  <= perf_fetched_r  + {31'd0, consumed_s};
      perf_bubbles_r  <= perf_bubbles_r  + {31'd0, bubble_s};
      perf_discards_r <= perf_discards_r + {31'd0, dropped_s};
    end
  end

  assign perf_fetched  = perf_fetched_r;
  assign perf_bubbles  = perf_bubbles_r;
  assign perf_discards = perf_discards_r;
`else
  logic unused_s;
  assign unused_s = bubble_s ^ dropped_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Memory returns
// ins(addr) = addr ^ 32'hA5A5_0000 for the presented address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        pc_write, ifid_load, ifid_flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_discards;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .pc_write      (pc_write),
    .ifid_load     (ifid_load),
    .ifid_flush    (ifid_flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles),
    .perf_discards (perf_discards)
`endif
  );

  // Full observation {valid, instr, pc4, req, addr} and bubble view without pc4
  wire [97:0] obs   = {ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr};
  wire [65:0] obs_b = {ifid_valid, ifid_instr, imem_req, imem_addr};
  logic [97:0] exp_f;
  logic [65:0] exp_b;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_src = 2'd0; pc_write = 1'b1; ifid_load = 1'b1;
    ifid_flush = 1'b0; imem_ready = 1'b1;
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_f = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL reset: got %h want %h", obs, exp_f); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if ({perf_fetched, perf_bubbles, perf_discards} !== 96'd0) begin
      n_bad++; $display("FAIL reset_perf: got %h want 0", {perf_fetched, perf_bubbles, perf_discards}); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_f = {1'b1, ins(32'(4*i)), 32'(4*i+4), 1'b1, 32'(4*i+4)};
      n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp_f); end
    end
  endtask

  task automatic test_wait();
    do_reset();
    step(); step();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL wait_bubble_%0d: got %h want %h", i, obs_b, exp_b); end
    end
    imem_ready = 1'b1;
    step();
    exp_f = {1'b1, ins(32'h8), 32'h0000_000C, 1'b1, 32'h0000_000C};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL wait_done: got %h want %h", obs, exp_f); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step();
    ifid_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_f = {1'b1, ins(32'h8), 32'h0000_000C, 1'b0, 32'h0000_000C};
      n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_f); end
    end
    ifid_load = 1'b1;
    step();
    exp_f = {1'b1, ins(32'hC), 32'h0000_0010, 1'b1, 32'h0000_0010};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL stall_release: got %h want %h", obs, exp_f); end
    // Buffer a word, then redirect out of HOLD with a flush
    ifid_load = 1'b0;
    step();
    exp_f = {1'b1, ins(32'hC), 32'h0000_0010, 1'b0, 32'h0000_0010};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL hold_enter: got %h want %h", obs, exp_f); end
    ifid_load = 1'b1; ifid_flush = 1'b1; pc_src = 2'd2; jump_target = 32'h0000_0080;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0080};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL hold_redirect: got %h want %h", obs_b, exp_b); end
    ifid_flush = 1'b0; pc_src = 2'd0;
    step();
    exp_f = {1'b1, ins(32'h80), 32'h0000_0084, 1'b1, 32'h0000_0084};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL hold_target: got %h want %h", obs, exp_f); end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    imem_ready = 1'b0; pc_src = 2'd1; branch_target = 32'h0000_0040; ifid_flush = 1'b1;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0014};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL br_flush: got %h want %h", obs_b, exp_b); end
    pc_src = 2'd0; ifid_flush = 1'b0;
    step();
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL br_pending: got %h want %h", obs_b, exp_b); end
    imem_ready = 1'b1;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0040};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL br_drop: got %h want %h", obs_b, exp_b); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (perf_discards !== 32'd1) begin n_bad++; $display("FAIL br_discards: got %0d want 1", perf_discards); end
`endif
    step();
    exp_f = {1'b1, ins(32'h40), 32'h0000_0044, 1'b1, 32'h0000_0044};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL br_target: got %h want %h", obs, exp_f); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if ({perf_fetched, perf_bubbles} !== {32'd6, 32'd2}) begin
      n_bad++; $display("FAIL br_counts: got %0d/%0d want 6/2", perf_fetched, perf_bubbles); end
`endif
  endtask

  task automatic test_jr();
    do_reset();
    step(); step();
    pc_src = 2'd3; jr_target = 32'h0000_0100; pc_write = 1'b0;
    step();
    exp_f = {1'b1, ins(32'h8), 32'h0000_000C, 1'b1, 32'h0000_000C};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL jr_ignored: got %h want %h", obs, exp_f); end
    pc_write = 1'b1;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL jr_redirect: got %h want %h", obs_b, exp_b); end
    pc_src = 2'd0;
    step();
    exp_f = {1'b1, ins(32'h100), 32'h0000_0104, 1'b1, 32'h0000_0104};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL jr_target: got %h want %h", obs, exp_f); end
  endtask

  task automatic test_wrap();
    do_reset();
    pc_src = 2'd2; jump_target = 32'hFFFF_FFFC; ifid_flush = 1'b1;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL wrap_jump: got %h want %h", obs_b, exp_b); end
    pc_src = 2'd0; ifid_flush = 1'b0;
    step();
    exp_f = {1'b1, 32'h5A5A_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL wrap_pc4: got %h want %h", obs, exp_f); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    imem_ready = 1'b0;
    step();
    exp_b = {1'b0, 32'h0000_0000, 1'b1, 32'h0000_0020};
    n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL rstmid_pending: got %h want %h", obs_b, exp_b); end
    rst = 1'b1;
    step();
    exp_f = {1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL rstmid_state: got %h want %h", obs, exp_f); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if ({perf_fetched, perf_bubbles, perf_discards} !== 96'd0) begin
      n_bad++; $display("FAIL rstmid_perf: got %h want 0", {perf_fetched, perf_bubbles, perf_discards}); end
`endif
    rst = 1'b0; imem_ready = 1'b1;
    step();
    exp_f = {1'b1, ins(32'h0), 32'h0000_0004, 1'b1, 32'h0000_0004};
    n_cmp++; if (obs !== exp_f) begin n_bad++; $display("FAIL rstmid_restart: got %h want %h", obs, exp_f); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_wait();
    test_stall();
    test_branch();
    test_jr();
    test_wrap();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
